// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Combined hazard-detect and forwarding controller for the in-order pipeline.
// A scoreboard shift register tracks every instruction past ID (slot 1 = EX,
// slot 2 = MEM, ...). The ID instruction's sources are matched against it to
// decide load-use stalls and to register the forwarding selects that the
// consumer uses while it sits in EX.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   id_valid_i                   ID instruction valid
//   id_rs_i, id_rt_i             source register addresses
//   id_use_rs_i, id_use_rt_i     source actually read
//   id_rd_i                      destination register address
//   id_regwrite_i                instruction writes the register file
//   id_memread_i                 instruction is a load
//   branch_taken_i               branch resolved taken in slot BR_SLOT
//   pc_write_o, ifid_write_o     PC / IF-ID enables (low on stall)
//   ifid_flush_o                 clear IF/ID (taken branch)
//   idex_bubble_o                insert zeroed controls into ID/EX
//   fwd_a_o, fwd_b_o             registered rs/rt operand source for EX
//   stall_cnt_o                  saturating load-use stall counter
module pipe_hazard_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LD_AVAIL = 3,
  parameter int unsigned BR_SLOT  = 2,
  parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [ADDR_W-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              branch_taken_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic [SEL_W-1:0]  fwd_a_o,
  output logic [SEL_W-1:0]  fwd_b_o,
  output logic [15:0]       stall_cnt_o
);

  // Only slots 1..DEPTH-1 can supply a forwarded value; the slot-DEPTH entry
  // is never read, so it is not stored (it simply retires on the next edge).
  localparam int unsigned NSLOT   = DEPTH - 1;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NSLOT:1]    v_q;
  logic [NSLOT:1]    wr_q;
  logic [NSLOT:1]    ld_q;
  logic [ADDR_W-1:0] rd_q [1:NSLOT];

  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic              ld_a;
  logic              ld_b;
  logic              early_a;
  logic              early_b;
  logic              stall;
  logic              flush;
  logic              issue;

  // Youngest-producer search: scan oldest to youngest so the lowest slot wins.
  // early_* flags a producer whose load data is not yet forwardable.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    early_a = 1'b0;
    early_b = 1'b0;
    for (int j = int'(NSLOT); j >= 1; j--) begin
      if (v_q[j] && wr_q[j] && (rd_q[j] != '0)) begin
        if (id_use_rs_i && (rd_q[j] == id_rs_i)) begin
          sel_a   = SEL_W'(j + 1);
          ld_a    = ld_q[j];
          early_a = ((j + 1) < int'(LD_AVAIL));
        end
        if (id_use_rt_i && (rd_q[j] == id_rt_i)) begin
          sel_b   = SEL_W'(j + 1);
          ld_b    = ld_q[j];
          early_b = ((j + 1) < int'(LD_AVAIL));
        end
      end
    end
  end

  // Hazard decisions; branch_taken_i is masked while in reset.
  assign stall = !rst_i && id_valid_i && ((ld_a && early_a) || (ld_b && early_b));
  assign flush = !rst_i && branch_taken_i;
  assign issue = id_valid_i && !stall && !flush;

  // Pipeline control outputs; a flush takes priority over a stall.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    if (flush) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (stall) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end
  end

  // Scoreboard shift, forwarding-select capture and stall counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q         <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      for (int k = 1; k <= int'(NSLOT); k++) begin
        rd_q[k] <= '0;
      end
      fwd_a_o     <= '0;
      fwd_b_o     <= '0;
      stall_cnt_o <= '0;
    end else begin
      // Entries younger than the taken branch are squashed as they advance.
      for (int k = 2; k <= int'(NSLOT); k++) begin
        v_q[k]  <= v_q[k-1] && !(flush && (k <= int'(BR_SLOT)));
        wr_q[k] <= wr_q[k-1];
        ld_q[k] <= ld_q[k-1];
        rd_q[k] <= rd_q[k-1];
      end

      if (issue) begin
        v_q[1]  <= 1'b1;
        wr_q[1] <= id_regwrite_i;
        ld_q[1] <= id_memread_i;
        rd_q[1] <= id_rd_i;
      end else begin
        v_q[1]  <= 1'b0;
        wr_q[1] <= 1'b0;
        ld_q[1] <= 1'b0;
        rd_q[1] <= '0;
      end

      // Producers move one slot older as the consumer enters EX; the search
      // already reports j+1, so the captured value is valid for EX.
      fwd_a_o <= issue ? sel_a : '0;
      fwd_b_o <= issue ? sel_b : '0;

      if (stall && !flush && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (default parameters): directed vector table,
// hand-written reset sequence, then random traffic against a queue-based model.
module tb_pipe_hazard_ctrl;

  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 3;
  localparam int LD_AVAIL = 3;
  localparam int BR_SLOT  = 2;
  localparam int SEL_W    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0;
  logic [ADDR_W-1:0] id_rs = '0;
  logic [ADDR_W-1:0] id_rt = '0;
  logic              id_use_rs = 1'b0;
  logic              id_use_rt = 1'b0;
  logic [ADDR_W-1:0] id_rd = '0;
  logic              id_regwrite = 1'b0;
  logic              id_memread = 1'b0;
  logic              branch_taken = 1'b0;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [SEL_W-1:0]  fwd_a;
  logic [SEL_W-1:0]  fwd_b;
  logic [15:0]       stall_cnt;

  pipe_hazard_ctrl #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .LD_AVAIL (LD_AVAIL),
    .BR_SLOT  (BR_SLOT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_use_rs_i    (id_use_rs),
    .id_use_rt_i    (id_use_rt),
    .id_rd_i        (id_rd),
    .id_regwrite_i  (id_regwrite),
    .id_memread_i   (id_memread),
    .branch_taken_i (branch_taken),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b),
    .stall_cnt_o    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              valid;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    bit              use_rs;
    bit              use_rt;
    logic [ADDR_W-1:0] rd;
    bit              regwrite;
    bit              memread;
    bit              br;
    bit              pcw;
    bit              ifw;
    bit              fl;
    bit              bub;
    int              fa;
    int              fb;
    int              cnt;
  } vec_t;

  typedef struct {
    bit              v;
    bit              wr;
    bit              ld;
    logic [ADDR_W-1:0] rd;
  } ent_t;

  int n_vec = 0;
  int n_err = 0;
  int n_cmp = 0;

  ent_t sb[$];
  int   m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (vector %0d, t=%0t)", nm, act, exp, n_vec, $time);
    end
  endtask

  function automatic vec_t mk(bit valid, int rs, int rt, bit urs, bit urt, int rd,
                              bit rw, bit mr, bit br, bit pcw, bit ifw, bit fl,
                              bit bub, int fa, int fb, int cnt);
    vec_t t;
    t.valid = valid;  t.rs = ADDR_W'(rs);  t.rt = ADDR_W'(rt);
    t.use_rs = urs;   t.use_rt = urt;      t.rd = ADDR_W'(rd);
    t.regwrite = rw;  t.memread = mr;      t.br = br;
    t.pcw = pcw;      t.ifw = ifw;         t.fl = fl;  t.bub = bub;
    t.fa = fa;        t.fb = fb;           t.cnt = cnt;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid     = t.valid;
    id_rs        = t.rs;
    id_rt        = t.rt;
    id_use_rs    = t.use_rs;
    id_use_rt    = t.use_rt;
    id_rd        = t.rd;
    id_regwrite  = t.regwrite;
    id_memread   = t.memread;
    branch_taken = t.br;
  endtask

  // Called at posedge+1: controls checked at negedge, registers at next posedge+1.
  task automatic run_cycle(input vec_t t);
    drive(t);
    n_vec++;
    @(negedge clk);
    chk("pc_write",    32'(pc_write),    32'(t.pcw));
    chk("ifid_write",  32'(ifid_write),  32'(t.ifw));
    chk("ifid_flush",  32'(ifid_flush),  32'(t.fl));
    chk("idex_bubble", 32'(idex_bubble), 32'(t.bub));
    @(posedge clk);
    #1;
    chk("fwd_a",     32'(fwd_a),     t.fa);
    chk("fwd_b",     32'(fwd_b),     t.fb);
    chk("stall_cnt", 32'(stall_cnt), t.cnt);
  endtask

  // Slot number (1-based) of the youngest forwardable producer, 0 if none.
  function automatic int youngest(input logic [ADDR_W-1:0] src, input bit use_it, output bit is_ld);
    is_ld = 1'b0;
    if (!use_it || src == '0) return 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (sb[i].v && sb[i].wr && sb[i].rd == src) begin
        is_ld = sb[i].ld;
        return i + 1;
      end
    end
    return 0;
  endfunction

  task automatic model_advance(input bit issue, input bit flush, input vec_t t);
    ent_t ne;
    if (flush) begin
      for (int i = 0; i < BR_SLOT - 1; i++) sb[i].v = 1'b0;
    end
    ne.v = issue; ne.wr = issue && t.regwrite; ne.ld = issue && t.memread;
    ne.rd = issue ? t.rd : '0;
    sb.push_front(ne);
    void'(sb.pop_back());
  endtask

  vec_t tbl[15];

  initial begin
    // Directed table; fa/fb/cnt are values after the vector's clock edge.
    tbl[0]  = mk(1, 1, 2, 1,1, 3, 1,0,0, 1,1,0,0, 0,0,0); // add $3<-$1,$2
    tbl[1]  = mk(1, 3, 5, 1,1, 4, 1,0,0, 1,1,0,0, 2,0,0); // sub $4<-$3,$5
    tbl[2]  = mk(1, 6, 3, 1,1, 7, 1,0,0, 1,1,0,0, 0,3,0); // rt=$3 from MEM
    tbl[3]  = mk(1, 1, 0, 1,0, 2, 1,1,0, 1,1,0,0, 0,0,0); // lw $2
    tbl[4]  = mk(1, 1, 2, 1,1, 6, 1,0,0, 0,0,0,1, 0,0,1); // add uses $2: stall
    tbl[5]  = mk(1, 1, 2, 1,1, 6, 1,0,0, 1,1,0,0, 0,3,1); // add reissues
    tbl[6]  = mk(1, 1, 0, 1,0, 0, 1,1,0, 1,1,0,0, 0,0,1); // lw $0
    tbl[7]  = mk(1, 0, 0, 1,1, 8, 1,0,0, 1,1,0,0, 0,0,1); // reads $0: nothing
    tbl[8]  = mk(1, 1, 0, 1,0, 4, 1,0,0, 1,1,0,0, 0,0,1); // addi $4
    tbl[9]  = mk(1, 5, 0, 1,0, 4, 1,0,0, 1,1,0,0, 0,0,1); // ori $4
    tbl[10] = mk(1, 4, 0, 1,0, 9, 1,0,0, 1,1,0,0, 2,0,1); // use $4: youngest
    tbl[11] = mk(1, 1, 0, 1,0,10, 1,1,0, 1,1,0,0, 0,0,1); // lw $10
    tbl[12] = mk(1,10,10, 1,1,11, 1,0,1, 1,1,1,1, 0,0,1); // stall + flush
    tbl[13] = mk(1,10,10, 1,1,11, 1,0,0, 1,1,0,0, 0,0,1); // squashed lw gone
    tbl[14] = mk(0,11,11, 1,1,12, 1,0,0, 1,1,0,0, 0,0,1); // invalid ID

    // Reset state, with branch_taken asserted to show it is ignored.
    branch_taken = 1'b1;
    #2;
    chk("rst_pc_write",   32'(pc_write),    32'd1);
    chk("rst_ifid_flush", 32'(ifid_flush),  32'd0);
    chk("rst_bubble",     32'(idex_bubble), 32'd0);
    chk("rst_fwd_a",      32'(fwd_a),       32'd0);
    chk("rst_stall_cnt",  32'(stall_cnt),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    branch_taken = 1'b0;

    for (int i = 0; i < 15; i++) run_cycle(tbl[i]);

    // Asynchronous reset mid-stream, during a live stall condition.
    run_cycle(mk(1, 1, 2, 1,1, 3, 1,0,0, 1,1,0,0, 0,0,1)); // add $3
    run_cycle(mk(1, 3, 0, 1,0, 5, 1,1,0, 1,1,0,0, 2,0,1)); // lw $5 <- $3
    drive(mk(1, 5, 5, 1,1, 6, 1,0,0, 1,1,0,0, 0,0,0));
    @(negedge clk);
    chk("pre_rst_stall", 32'(pc_write), 32'd0);
    #2;
    rst = 1'b1;
    branch_taken = 1'b1;
    #1;
    chk("arst_pc_write",   32'(pc_write),    32'd1);
    chk("arst_ifid_write", 32'(ifid_write),  32'd1);
    chk("arst_ifid_flush", 32'(ifid_flush),  32'd0);
    chk("arst_bubble",     32'(idex_bubble), 32'd0);
    chk("arst_fwd_a",      32'(fwd_a),       32'd0);
    chk("arst_fwd_b",      32'(fwd_b),       32'd0);
    chk("arst_stall_cnt",  32'(stall_cnt),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    branch_taken = 1'b0;
    run_cycle(mk(1, 5, 5, 1,1, 6, 1,0,0, 1,1,0,0, 0,0,0)); // no stall after reset

    // Model picks up the state left by the last instruction.
    sb.delete();
    for (int i = 0; i < DEPTH; i++) sb.push_back('{v: 1'b0, wr: 1'b0, ld: 1'b0, rd: '0});
    m_cnt = 0;
    model_advance(1'b1, 1'b0, mk(1, 5, 5, 1,1, 6, 1,0,0, 1,1,0,0, 0,0,0));

    for (int c = 0; c < 1500; c++) begin
      vec_t t;
      int   da;
      int   db;
      bit   la;
      bit   lb;
      bit   stall;
      bit   flush;
      bit   issue;
      t.valid    = ($urandom_range(0, 9) < 8);
      t.rs       = ADDR_W'($urandom_range(0, 3));
      t.rt       = ADDR_W'($urandom_range(0, 3));
      t.use_rs   = 1'($urandom_range(0, 1));
      t.use_rt   = 1'($urandom_range(0, 1));
      t.rd       = ADDR_W'($urandom_range(0, 3));
      t.regwrite = ($urandom_range(0, 3) != 0);
      t.memread  = ($urandom_range(0, 2) == 0);
      t.br       = ($urandom_range(0, 7) == 0);
      da = youngest(t.rs, t.use_rs, la);
      db = youngest(t.rt, t.use_rt, lb);
      stall = t.valid && ((da != 0 && la && da + 1 < LD_AVAIL) ||
                          (db != 0 && lb && db + 1 < LD_AVAIL));
      flush = t.br;
      issue = t.valid && !stall && !flush;
      t.pcw = !stall || flush;
      t.ifw = !stall || flush;
      t.fl  = flush;
      t.bub = stall || flush;
      t.fa  = (issue && da != 0) ? da + 1 : 0;
      t.fb  = (issue && db != 0) ? db + 1 : 0;
      if (stall && !flush && m_cnt < 65535) m_cnt++;
      t.cnt = m_cnt;
      run_cycle(t);
      model_advance(issue, flush, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order pipelined CPU. It replaces the separate hazard-detect and forwarding units with one block, configurable in pipeline depth, load-data latency and branch-resolution stage. It tracks every in-flight instruction past decode in an internal scoreboard shift register. From that it produces PC/IF-ID stall, IF-ID flush and ID-EX bubble controls, plus registered operand-forwarding selects that are valid while the consumer sits in EX.

## Interface
Parameters:
- ADDR_W, 5, register-address width.
- DEPTH, 3, number of scoreboard slots past ID. Slot 1 is EX, slot 2 is MEM, slot 3 is WB. DEPTH ≥ 2.
- LD_AVAIL, 3, first slot from which a load result is forwardable. 2 ≤ LD_AVAIL ≤ DEPTH.
- BR_SLOT, 2, slot in which the branch is resolved. 2 ≤ BR_SLOT ≤ DEPTH.
- SEL_W, clog2(DEPTH+1), width of the forward selects. Derived; do not override.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- id_valid_i  in  1  the ID-stage instruction is valid.
- id_rs_i, id_rt_i  in  ADDR_W  source register addresses.
- id_use_rs_i, id_use_rt_i  in  1  the source is actually read.
- id_rd_i  in  ADDR_W  destination register address.
- id_regwrite_i  in  1  the instruction writes the register file.
- id_memread_i  in  1  the instruction is a load.
- branch_taken_i  in  1  the branch in slot BR_SLOT is taken.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register enable.
- ifid_flush_o  out  1  clear IF/ID.
- idex_bubble_o  out  1  load zeroed controls into ID/EX.
- fwd_a_o, fwd_b_o  out  SEL_W  rs/rt operand source for the instruction in EX. 0 selects the register-file value; k selects the result held in slot k.
- stall_cnt_o  out  16  count of load-use stall cycles.

## Operation
- Scoreboard:
  - Each slot k holds {v, wr, ld, rd}.
  - On every edge, slot k+1 takes slot k, for k = 1..DEPTH-1. The slot-DEPTH entry retires.
- Slot 1 load:
  - It takes {1, id_regwrite_i, id_memread_i, id_rd_i} when id_valid_i=1, with no stall and no flush.
  - Otherwise it takes all zeros.
- Producer match (combinational, evaluated for slots j = 1..DEPTH-1):
  - A slot matches a source when v & wr & rd≠0 & rd==src & use.
  - Only the lowest matching j (the youngest producer) counts.
- Load-use stall:
  - stall = id_valid_i & (youngest match on rs or rt has ld=1) & (j+1 < LD_AVAIL).
  - On a stall: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, and slot 1 takes a bubble.
- Forward selects:
  - On each non-stalled, non-flushed issue edge, fwd_a_o/fwd_b_o register j+1 for the youngest match, or 0 if there is none.
  - On a stall or flush edge they register 0.
- Flush:
  - branch_taken_i=1 drives ifid_flush_o=1, idex_bubble_o=1 and pc_write_o=1. ifid_write_o=1.
  - Flush overrides stall.
  - On that edge, slots 1..BR_SLOT-1 are invalidated as they advance (destinations 2..BR_SLOT get v=0). Slot 1 takes a bubble.
  - The branch entry itself advances normally.
- stall_cnt_o:
  - Increments on every edge where stall=1 and branch_taken_i=0.
  - Saturates at 0xFFFF.
- Idle outputs: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0.

## Timing
- Reset:
  - While rst_i is high, all slots are zero, fwd_a_o = fwd_b_o = 0 and stall_cnt_o = 0. This takes effect immediately and asynchronously.
  - branch_taken_i is ignored during reset, so the control outputs sit at their idle values.
- Latency:
  - Stall, flush and bubble outputs are combinational, in the same cycle as the ID inputs.
  - Forward selects are registered and valid one cycle after issue, for the whole EX cycle.
- Stall length with defaults: exactly 1 cycle for a load immediately followed by its consumer. A consumer two or more behind the load does not stall.
- General load-use stall length: LD_AVAIL-2 cycles. The condition re-evaluates each cycle as the load advances.
- Reset deasserted mid-stream: the first post-reset instruction sees an empty scoreboard, so no stall and fwd = 0.

## Test plan
Defaults throughout: DEPTH=3, LD_AVAIL=3, BR_SLOT=2.
- Back-to-back ALU dependency. Issue add $3←$1,$2, then sub $4←$3,$5. No stall; fwd_a_o=2 in sub's EX cycle. A third instruction using $3 rt gets fwd_b_o=3.
- Load-use. Issue lw $2, then add $6←$1,$2. pc_write_o and ifid_write_o are 0 and idex_bubble_o is 1 for exactly one cycle. Add's EX then shows fwd_b_o=3. stall_cnt_o goes 0→1.
- Register zero. The producer writes $0 and the consumer reads $0. No stall, and fwd_a_o = fwd_b_o = 0.
- Double producer. Issue addi $4, then ori $4, then use $4. fwd_a_o=2 (youngest producer), not 3.
- Flush beats stall. Hold a load-use stall condition and assert branch_taken_i in the same cycle. Required: pc_write_o=1, ifid_flush_o=1, idex_bubble_o=1, slot 1 invalidated, stall_cnt_o unchanged.
- Reset. Assert rst_i mid-stream with valid slots. fwd_*=0, stall_cnt_o=0, outputs idle, all asynchronously and before the next edge. After release, a dependent instruction yields no stall.
